serial_bit_feeder: RTL and testbench
====================================

Name: serial_bit_feeder

Overview:
- Parallel-to-serial stage directly upstream of the serial pattern detector.
- Accepts parallel words over a valid/ready handshake and emits them one bit per clock on a single-bit stream with a qualifying valid.
- Supports back-to-back words with no idle cycle, so patterns that span word boundaries reach the detector intact.
- Downstream connects `out` to the detector's serial input and uses `out_valid` to qualify it.

Parameters:
- WIDTH, 8, word width in bits; legal range is WIDTH >= 2.
- LSB_FIRST, 0, selects serial order: 0 = MSB first, 1 = LSB first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  din holds a word for transfer.
- din_ready  output  1  block can accept a word this cycle.
- out  output  1  serial data bit.
- out_valid  output  1  out carries a valid bit.
- busy  output  1  a word is being shifted.
- done  output  1  one-cycle pulse coinciding with the final serial bit of a word.

Behaviour:
- Reset:
  - When reset is low, asynchronously force state=IDLE, shift register=0, bit counter=0, out=0, out_valid=0, busy=0, done=0.
  - din_ready=1 while in reset.
- Handshake:
  - A transfer occurs on a rising clk edge where din_valid=1 and din_ready=1.
  - din is captured only on a transfer.
  - din_valid held high while din_ready=0 is ignored; no capture and no error.
- State machine (2 states, registered):
  - IDLE: din_ready=1. On transfer, load the word and go to SHIFT with counter=0.
  - SHIFT: one bit per cycle; the counter increments each cycle.
  - When counter=WIDTH-1 (last bit): on a transfer, reload and stay in SHIFT with counter=0; otherwise go to IDLE.
- din_ready:
  - Combinational: 1 in IDLE, and 1 in SHIFT only when counter=WIDTH-1.
  - Otherwise 0.
- Outputs (all registered):
  - Latency: word accepted at edge N → first bit on out in the cycle following edge N.
  - Bit k of the word appears in cycle N+1+k.
  - out_valid=1 and busy=1 for exactly WIDTH consecutive cycles per word.
  - out=0 whenever out_valid=0.
- Serial order:
  - LSB_FIRST=0: din[WIDTH-1] first, down to din[0].
  - LSB_FIRST=1: din[0] first, up to din[WIDTH-1].
- Back-to-back: a transfer on the last-bit cycle yields a continuous stream with out_valid staying high and no gap bit.
- done: high in the same cycle as the last bit of each word; back-to-back words give one pulse per word.
- Counter width: $clog2(WIDTH). The counter never exceeds WIDTH-1; the wrap to 0 occurs only on reload or return to IDLE.
- Reset mid-word: the word is abandoned, outputs clear immediately, and no done pulse is produced. The first word after reset release starts cleanly from IDLE.

Optional Feature:
- Macro: SERIAL_FEEDER_PARITY_EN.
- Defined:
  - An extra PARITY state follows the last data bit.
  - In that cycle, out = XOR of all captured data bits (even parity) with out_valid=1.
  - done moves to the parity cycle.
  - din_ready is high in the PARITY state instead of on the last data bit.
  - Each word occupies WIDTH+1 stream cycles.
- Undefined: no PARITY state exists and behaviour is exactly as above.

Test Plan:
- Single word, WIDTH=8, LSB_FIRST=0: din=8'hB0 accepted at edge N → out=1,0,1,1,0,0,0,0 in cycles N+1..N+8; out_valid high for exactly 8 cycles; done only at N+8; then din_ready=1, out=0, out_valid=0.
- Back-to-back: 8'hA5 then 8'h5A, din_valid held high → 16 consecutive valid bits 10100101 01011010, no gap, two done pulses at cycles 8 and 16.
- Hold-off: din_valid=1 with din changing during cycles 2..7 of a word → din_ready=0 and stream unchanged; next word captured only at the last-bit edge.
- LSB_FIRST=1: din=8'h0D → out=1,0,1,1,0,0,0,0.
- Reset asserted at bit 4 of 8'hFF → out, out_valid and busy go to 0 without waiting for clk; no done; after release, 8'h81 serializes as 1,0,0,0,0,0,0,1.
- With SERIAL_FEEDER_PARITY_EN defined: 8'hB0 → 9 valid bits 1,0,1,1,0,0,0,0,1; done on the 9th bit; 8'h00 → 9th bit 0.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on valid/ready and streams them
// one bit per clock. Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit per word.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_q, out_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             xfer;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par_q, par_d;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // The shift register always holds the bits still to be sent, next one at the head.
  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    din_ready = 1'b0;
    case (state_q)
      IDLE:   din_ready = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      SHIFT:  din_ready = 1'b0;
      PARITY: din_ready = 1'b1;
`else
      SHIFT:  din_ready = (cnt_q == LAST);
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign xfer    = din_valid & din_ready;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    out_d   = 1'b0;
    vld_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_d   = par_q;
`endif
    if (xfer) begin
      state_d = SHIFT;
      cnt_d   = '0;
      sreg_d  = shift_word(din);
      out_d   = first_bit(din);
      vld_d   = 1'b1;
      busy_d  = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_d   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q != LAST) begin
            cnt_d  = cnt_inc;
            sreg_d = shift_word(sreg_q);
            out_d  = first_bit(sreg_q);
            vld_d  = 1'b1;
            busy_d = 1'b1;
`ifndef SERIAL_FEEDER_PARITY_EN
            done_d = (cnt_inc == LAST);
`endif
          end else begin
`ifdef SERIAL_FEEDER_PARITY_EN
            state_d = PARITY;
            out_d   = par_q;
            vld_d   = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b1;
`else
            state_d = IDLE;
            cnt_d   = '0;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: MSB-first and LSB-first instances, back-to-back,
// hold-off and asynchronous reset cases; honours SERIAL_FEEDER_PARITY_EN.
module tb_serial_bit_feeder;

`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int SL = 9;
  localparam logic [17:0] EXP_AB = {8'hA5, 1'b0, 8'h5A, 1'b0};
  localparam logic P_B0 = 1'b1, P_0D = 1'b1, P_81 = 1'b0, P_00 = 1'b0;
`else
  localparam int SL = 8;
  localparam logic [17:0] EXP_AB = {2'b00, 8'hA5, 8'h5A};
  localparam logic P_B0 = 1'b0, P_0D = 1'b0, P_81 = 1'b0, P_00 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] a_din, b_din;
  logic a_vld, b_vld;
  logic a_rdy, a_out, a_ov, a_busy, a_done;
  logic b_rdy, b_out, b_ov, b_busy, b_done;
  logic sel;
  logic o_rdy, o_out, o_ov, o_busy, o_done;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(rst_n), .din(a_din), .din_valid(a_vld), .din_ready(a_rdy),
    .out(a_out), .out_valid(a_ov), .busy(a_busy), .done(a_done)
  );

  serial_bit_feeder #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(rst_n), .din(b_din), .din_valid(b_vld), .din_ready(b_rdy),
    .out(b_out), .out_valid(b_ov), .busy(b_busy), .done(b_done)
  );

  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_out  = sel ? b_out  : a_out;
  assign o_ov   = sel ? b_ov   : a_ov;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // exp[8] is the first stream bit; exp[0] is only used when the parity bit exists.
  task automatic run_word(input bit s, input logic [7:0] w, input logic [8:0] exp,
                          input string tag);
    sel = s;
    @(negedge clk);
    if (s) begin b_din = w; b_vld = 1'b1; end
    else   begin a_din = w; a_vld = 1'b1; end
    #1 check({tag, "_rdy0"}, 32'(o_rdy), 32'd1);
    for (int k = 0; k < SL; k++) begin
      @(negedge clk);
      if (k == 0) begin a_vld = 1'b0; b_vld = 1'b0; end
      check($sformatf("%s_bit%0d", tag, k), 32'(o_out), 32'(exp[8-k]));
      check($sformatf("%s_ov%0d", tag, k), 32'(o_ov), 32'd1);
      check($sformatf("%s_busy%0d", tag, k), 32'(o_busy), 32'd1);
      check($sformatf("%s_done%0d", tag, k), 32'(o_done), 32'(k == SL - 1));
      check($sformatf("%s_rdy%0d", tag, k), 32'(o_rdy), 32'(k == SL - 1));
    end
    @(negedge clk);
    check({tag, "_idle_ov"}, 32'(o_ov), 32'd0);
    check({tag, "_idle_out"}, 32'(o_out), 32'd0);
    check({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_idle_rdy"}, 32'(o_rdy), 32'd1);
  endtask

  initial begin
    logic [17:0] e;
    rst_n = 1'b0;
    sel   = 1'b0;
    a_din = '0; a_vld = 1'b0;
    b_din = '0; b_vld = 1'b0;
    #1;
    check("rst_rdy", 32'(a_rdy), 32'd1);
    check("rst_out", 32'(a_out), 32'd0);
    check("rst_ov", 32'(a_ov), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_word(1'b0, 8'hB0, {8'b1011_0000, P_B0}, "b0");
    run_word(1'b1, 8'h0D, {8'b1011_0000, P_0D}, "lsb0d");
    run_word(1'b0, 8'h00, {8'b0000_0000, P_00}, "z00");

    // Back-to-back A5/5A with din_valid held high and din churning while not ready.
    e = EXP_AB;
    sel = 1'b0;
    @(negedge clk);
    a_din = 8'hA5; a_vld = 1'b1;
    for (int c = 0; c < 2 * SL; c++) begin
      @(negedge clk);
      check($sformatf("b2b_bit%0d", c), 32'(a_out), 32'(e[2*SL-1-c]));
      check($sformatf("b2b_ov%0d", c), 32'(a_ov), 32'd1);
      check($sformatf("b2b_done%0d", c), 32'(a_done), 32'((c == SL - 1) || (c == 2 * SL - 1)));
      if (c < SL - 1) begin
        check($sformatf("b2b_hold_rdy%0d", c), 32'(a_rdy), 32'd0);
        a_din = 8'h3C ^ c[7:0];
      end else if (c == SL - 1) begin
        check("b2b_last_rdy", 32'(a_rdy), 32'd1);
        a_din = 8'h5A;
      end else if (c == SL) begin
        a_vld = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b_end_ov", 32'(a_ov), 32'd0);

    // Asynchronous reset in the middle of an all-ones word.
    @(negedge clk);
    a_din = 8'hFF; a_vld = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 0) a_vld = 1'b0;
      check($sformatf("ff_bit%0d", k), 32'(a_out), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'(a_out), 32'd0);
    check("arst_ov", 32'(a_ov), 32'd0);
    check("arst_busy", 32'(a_busy), 32'd0);
    check("arst_done", 32'(a_done), 32'd0);
    check("arst_rdy", 32'(a_rdy), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("arst_hold_done%0d", k), 32'(a_done), 32'd0);
      check($sformatf("arst_hold_ov%0d", k), 32'(a_ov), 32'd0);
    end
    rst_n = 1'b1;
    run_word(1'b0, 8'h81, {8'b1000_0001, P_81}, "post81");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
